// File: rtl/mem_bridge_if.sv
// Core-side request/response and RAM-side strobe/data signals of mem_bridge.
// Request handshake: the core holds cpu_r or cpu_w high (level) with stable
// address/data/size/sign until it sees the one-cycle cpu_ready pulse, and drops
// the request in that same cycle; cpu_err qualifies cpu_ready.
interface mem_bridge_if;
  logic        cpu_r;
  logic        cpu_w;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_sign;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // Environment side: core requests and RAM read data.
  modport master (
    output cpu_r, cpu_w, cpu_addr, cpu_wdata, cpu_size, cpu_sign, ram_rdata,
    input  cpu_rdata, cpu_ready, cpu_err, ram_en, ram_we, ram_addr, ram_wdata
  );

  // Bridge side.
  modport slave (
    input  cpu_r, cpu_w, cpu_addr, cpu_wdata, cpu_size, cpu_sign, ram_rdata,
    output cpu_rdata, cpu_ready, cpu_err, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_bridge.sv
// Converts byte/halfword/word CPU loads and stores into lane-masked accesses
// on a synchronous word-wide RAM with WAIT_CYCLES read latency.
module mem_bridge #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_bridge_if.slave bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic        store_q;
  logic [29:0] addr_q;
  logic [31:0] rdata_q;
  logic        en_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;

  logic        illegal;
  logic [3:0]  we_calc;
  logic [31:0] wd_calc;
  logic [31:0] load_ext;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Alignment check and store lane/data formatting from the incoming request.
  always_comb begin
    illegal = 1'b0;
    we_calc = 4'b0000;
    wd_calc = bus.cpu_wdata;
    case (bus.cpu_size)
      2'b00: begin
        illegal = (bus.cpu_addr[1:0] != 2'b00);
        we_calc = 4'b1111;
        wd_calc = bus.cpu_wdata;
      end
      2'b01: begin
        illegal = bus.cpu_addr[0];
        we_calc = 4'b0011 << bus.cpu_addr[1:0];
        wd_calc = {2{bus.cpu_wdata[15:0]}};
      end
      2'b10: begin
        we_calc = 4'b0001 << bus.cpu_addr[1:0];
        wd_calc = {4{bus.cpu_wdata[7:0]}};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Little-endian lane select and zero/sign extension of RAM read data.
  always_comb begin
    half_sel = off_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    byte_sel = bus.ram_rdata[8*off_q +: 8];
    case (size_q)
      2'b01:   load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
      2'b10:   load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
      default: load_ext = bus.ram_rdata;
    endcase
  end

  // Access sequencer; RAM strobes are registered so reset drops them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      addr_q  <= 30'd0;
      rdata_q <= 32'd0;
      en_q    <= 1'b0;
      we_q    <= 4'b0000;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_r || bus.cpu_w) begin
            addr_q  <= bus.cpu_addr[31:2];
            off_q   <= bus.cpu_addr[1:0];
            size_q  <= bus.cpu_size;
            sign_q  <= bus.cpu_sign;
            store_q <= bus.cpu_w;
            if (illegal) begin
              state <= ERR;
            end else begin
              state   <= ACCESS;
              en_q    <= 1'b1;
              we_q    <= bus.cpu_w ? we_calc : 4'b0000;
              wdata_q <= wd_calc;
            end
          end
        end
        ACCESS: begin
          en_q <= 1'b0;
          we_q <= 4'b0000;
          if (store_q) begin
            state <= DONE;
          end else begin
            state <= WAIT;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            rdata_q <= load_ext;
            cnt     <= 4'd0;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = (state == DONE) || (state == ERR);
  assign bus.cpu_err   = (state == ERR);
  assign bus.ram_en    = en_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign dbg_state     = state;

endmodule
